// File: rtl/lsu_axi.sv
// Load/store unit bridging one EXU request at a time onto AXI4-Lite.
// Ports: EXU/WBU valid-ready handshake, pass-through fields, AXI4-Lite read/write master.
module lsu_axi (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_receive_valid,
    output logic        lsu_send_ready,
    input  logic [31:0] alu_result_input,
    input  logic [31:0] rsb_input,
    input  logic        ren_input,
    input  logic        wen_input,
    input  logic        memory_read_signed_input,
    input  logic        reg_write_en_input,
    input  logic [7:0]  wmask_input,
    input  logic [31:0] rmask_input,
    input  logic [4:0]  rd_input,
    input  logic [31:0] pc_next_input,
    output logic        lsu_send_valid,
    input  logic        lsu_receive_ready,
    output logic [31:0] result,
    output logic [4:0]  rd,
    output logic        reg_write_en,
    output logic [31:0] pc_next,
    output logic        mem_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, DONE} state_t;

    state_t      state;
    logic [31:0] alu_q;
    logic [31:0] rmask_q;
    logic [1:0]  off_q;
    logic        signed_q;
    logic        aw_done;
    logic        w_done;

    logic [1:0]  in_off;
    logic [31:0] wdata_next;
    logic [3:0]  wstrb_next;
    logic [31:0] load_data;
    logic        aw_hs;
    logic        w_hs;
    logic        unused_wmask;

    assign lsu_send_ready = (state == IDLE);
    assign unused_wmask   = ^wmask_input[7:4];

    // Lane placement for stores, taken straight from the request.
    assign in_off     = alu_result_input[1:0];
    assign wdata_next = rsb_input << {in_off, 3'b000};
    assign wstrb_next = wmask_input[3:0] << in_off;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // Align the addressed byte lane to bit 0, mask, then sign-extend.
    always_comb begin
        load_data = (rdata >> {off_q, 3'b000}) & rmask_q;
        if (signed_q && rmask_q == 32'h0000_00FF) begin
            load_data = {{24{load_data[7]}}, load_data[7:0]};
        end else if (signed_q && rmask_q == 32'h0000_FFFF) begin
            load_data = {{16{load_data[15]}}, load_data[15:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            alu_q          <= '0;
            rmask_q        <= '0;
            off_q          <= '0;
            signed_q       <= 1'b0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            lsu_send_valid <= 1'b0;
            result         <= '0;
            rd             <= '0;
            reg_write_en   <= 1'b0;
            pc_next        <= '0;
            mem_err        <= 1'b0;
            araddr         <= '0;
            arvalid        <= 1'b0;
            rready         <= 1'b0;
            awaddr         <= '0;
            awvalid        <= 1'b0;
            wdata          <= '0;
            wstrb          <= '0;
            wvalid         <= 1'b0;
            bready         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (lsu_receive_valid) begin
                        alu_q        <= alu_result_input;
                        rmask_q      <= rmask_input;
                        off_q        <= in_off;
                        signed_q     <= memory_read_signed_input;
                        rd           <= rd_input;
                        reg_write_en <= reg_write_en_input;
                        pc_next      <= pc_next_input;
                        mem_err      <= 1'b0;
                        // A load takes priority; a simultaneous store is dropped.
                        if (ren_input) begin
                            araddr  <= {alu_result_input[31:2], 2'b00};
                            arvalid <= 1'b1;
                            state   <= AR;
                        end else if (wen_input) begin
                            awaddr  <= {alu_result_input[31:2], 2'b00};
                            wdata   <= wdata_next;
                            wstrb   <= wstrb_next;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= AW_W;
                        end else begin
                            result         <= alu_result_input;
                            lsu_send_valid <= 1'b1;
                            state          <= DONE;
                        end
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        rready         <= 1'b0;
                        result         <= load_data;
                        mem_err        <= (rresp != 2'b00);
                        lsu_send_valid <= 1'b1;
                        state          <= DONE;
                    end
                end
                AW_W: begin
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    // Either channel may finish first, or both together.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        bready <= 1'b1;
                        state  <= B;
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready         <= 1'b0;
                        result         <= alu_q;
                        mem_err        <= (bresp != 2'b00);
                        lsu_send_valid <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    if (lsu_receive_ready) begin
                        lsu_send_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_axi.sv
// Testbench for lsu_axi: directed and random requests against an AXI slave model.
// Expected results come from arithmetic on the request, not from the DUT.
module tb_lsu_axi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_receive_valid = 1'b0;
    logic        lsu_send_ready;
    logic [31:0] alu_result_input = '0;
    logic [31:0] rsb_input = '0;
    logic        ren_input = 1'b0;
    logic        wen_input = 1'b0;
    logic        memory_read_signed_input = 1'b0;
    logic        reg_write_en_input = 1'b0;
    logic [7:0]  wmask_input = '0;
    logic [31:0] rmask_input = '0;
    logic [4:0]  rd_input = '0;
    logic [31:0] pc_next_input = '0;
    logic        lsu_send_valid;
    logic        lsu_receive_ready = 1'b0;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        reg_write_en;
    logic [31:0] pc_next;
    logic        mem_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0;
    logic        bready;

    lsu_axi dut (
        .clk(clk), .rst(rst),
        .lsu_receive_valid(lsu_receive_valid), .lsu_send_ready(lsu_send_ready),
        .alu_result_input(alu_result_input), .rsb_input(rsb_input),
        .ren_input(ren_input), .wen_input(wen_input),
        .memory_read_signed_input(memory_read_signed_input),
        .reg_write_en_input(reg_write_en_input),
        .wmask_input(wmask_input), .rmask_input(rmask_input),
        .rd_input(rd_input), .pc_next_input(pc_next_input),
        .lsu_send_valid(lsu_send_valid), .lsu_receive_ready(lsu_receive_ready),
        .result(result), .rd(rd), .reg_write_en(reg_write_en),
        .pc_next(pc_next), .mem_err(mem_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave behaviour for the next transaction.
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly, hold;
    logic [31:0] mem_rdata;
    logic [1:0]  resp_val;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle;
        arready = 1'b0;
        rvalid  = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [31:0] rm, input logic sg);
        logic [31:0] d;
        d = (word >> (8 * addr[1:0])) & rm;
        if (sg && rm == 32'hFF && d >= 32'd128) d = d - 32'd256;
        if (sg && rm == 32'hFFFF && d >= 32'd32768) d = d - 32'd65536;
        return d;
    endfunction

    task automatic run(input logic rn, input logic wn, input logic sg, input logic rw,
                       input logic [31:0] addr, input logic [31:0] rsbv,
                       input logic [7:0] wm, input logic [31:0] rm,
                       input logic [4:0] rdv, input logic [31:0] pcv);
        int n, arw, rww, aww, ww, bw, awhi, whi, vhi;
        bit seen_ar, seen_aw, seen_w, bad_b;
        logic [31:0] exp_res, exp_wdata, word_addr;
        logic [3:0]  exp_wstrb;
        int exp_lat, mx;
        n = 1; arw = 0; rww = 0; aww = 0; ww = 0; bw = 0; awhi = 0; whi = 0;
        seen_ar = 0; seen_aw = 0; seen_w = 0; bad_b = 0;
        word_addr = addr & 32'hFFFF_FFFC;
        exp_wdata = rsbv << (8 * addr[1:0]);
        exp_wstrb = 4'((32'(wm & 8'h0F) << addr[1:0]) & 32'hF);
        mx = (aw_dly > w_dly) ? aw_dly : w_dly;
        if (rn) begin
            exp_res = model_load(mem_rdata, addr, rm, sg);
            exp_lat = 3 + ar_dly + r_dly;
        end else if (wn) begin
            exp_res = addr;
            exp_lat = 3 + mx + b_dly;
        end else begin
            exp_res = addr;
            exp_lat = 1;
        end

        chk("send_ready_idle", 32'(lsu_send_ready), 32'd1);
        alu_result_input = addr;
        rsb_input = rsbv;
        ren_input = rn;
        wen_input = wn;
        memory_read_signed_input = sg;
        reg_write_en_input = rw;
        wmask_input = wm;
        rmask_input = rm;
        rd_input = rdv;
        pc_next_input = pcv;
        lsu_receive_valid = 1'b1;
        lsu_receive_ready = 1'b0;
        tick;
        lsu_receive_valid = 1'b0;
        alu_result_input = $urandom;
        rsb_input = $urandom;
        rd_input = 5'($urandom);
        pc_next_input = $urandom;
        rmask_input = $urandom;
        chk("mem_err_cleared", 32'(mem_err), 32'd0);
        chk("send_ready_busy", 32'(lsu_send_ready), 32'd0);

        while (!lsu_send_valid && n < 100) begin
            if (arvalid) begin
                if (!seen_ar) chk("araddr", araddr, word_addr);
                seen_ar = 1;
                if (arw == ar_dly) arready = 1'b1;
                else begin arready = 1'b0; arw++; end
            end else arready = 1'b0;
            rvalid = 1'b0;
            if (rready) begin
                if (rww == r_dly) begin
                    rvalid = 1'b1;
                    rdata = mem_rdata;
                    rresp = resp_val;
                end else begin
                    rdata = $urandom;
                    rww++;
                end
            end
            if (awvalid) begin
                awhi++;
                if (!seen_aw) chk("awaddr", awaddr, word_addr);
                seen_aw = 1;
                if (aww == aw_dly) awready = 1'b1;
                else begin awready = 1'b0; aww++; end
            end else awready = 1'b0;
            if (wvalid) begin
                whi++;
                if (!seen_w) begin
                    chk("wdata", wdata, exp_wdata);
                    chk("wstrb", 32'(wstrb), 32'(exp_wstrb));
                end
                seen_w = 1;
                if (ww == w_dly) wready = 1'b1;
                else begin wready = 1'b0; ww++; end
            end else wready = 1'b0;
            bvalid = 1'b0;
            if (bready) begin
                if (awvalid || wvalid) bad_b = 1;
                if (bw == b_dly) begin
                    bvalid = 1'b1;
                    bresp = resp_val;
                end else bw++;
            end
            tick;
            n++;
        end
        slave_idle;

        if (!lsu_send_valid) begin
            chk("timeout_send_valid", 32'(lsu_send_valid), 32'd1);
            rst = 1'b1;
            tick;
            rst = 1'b0;
            return;
        end

        chk("latency", 32'(n), 32'(exp_lat));
        chk("result", result, exp_res);
        chk("rd", 32'(rd), 32'(rdv));
        chk("pc_next", pc_next, pcv);
        chk("reg_write_en", 32'(reg_write_en), 32'(rw));
        chk("mem_err", 32'(mem_err), 32'((rn || wn) && resp_val != 2'b00));
        chk("bready_early", 32'(bad_b), 32'd0);
        if (!rn && wn) begin
            chk("awvalid_cycles", 32'(awhi), 32'(aw_dly + 1));
            chk("wvalid_cycles", 32'(whi), 32'(w_dly + 1));
        end else begin
            chk("no_write_issued", 32'(awhi + whi), 32'd0);
        end
        if (!rn && !wn) chk("no_read_issued", 32'(seen_ar), 32'd0);

        vhi = 1;
        for (int i = 0; i < hold; i++) begin
            tick;
            if (lsu_send_valid) vhi++;
            chk("result_stable", result, exp_res);
            chk("send_ready_done", 32'(lsu_send_ready), 32'd0);
        end
        chk("send_valid_cycles", 32'(vhi), 32'(hold + 1));
        lsu_receive_ready = 1'b1;
        tick;
        lsu_receive_ready = 1'b0;
        chk("send_valid_drop", 32'(lsu_send_valid), 32'd0);
    endtask

    task automatic defaults;
        ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0; hold = 0;
        resp_val = 2'b00;
        mem_rdata = $urandom;
    endtask

    initial begin
        logic [31:0] rmasks [3];
        logic        rn, wn;
        rmasks[0] = 32'hFF;
        rmasks[1] = 32'hFFFF;
        rmasks[2] = 32'hFFFF_FFFF;

        rst = 1'b1;
        tick;
        tick;
        chk("rst_send_valid", 32'(lsu_send_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_pc_next", pc_next, 32'd0);
        chk("rst_axi_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        chk("rst_axi_addr", araddr | awaddr | wdata | 32'(wstrb), 32'd0);
        rst = 1'b0;
        tick;
        chk("post_rst_send_ready", 32'(lsu_send_ready), 32'd1);

        // Signed byte load from the top lane.
        defaults;
        mem_rdata = 32'h80FF_FFFF;
        run(1, 0, 1, 1, 32'h8000_0003, 32'h0, 8'h0, 32'hFF, 5'd3, 32'h8000_0010);

        // Halfword store into the upper half.
        defaults;
        run(0, 1, 0, 0, 32'h8000_0002, 32'h0000_1234, 8'h03, 32'h0, 5'd0, 32'h8000_0014);

        // Write data channel four cycles behind the address channel.
        defaults;
        w_dly = 4;
        b_dly = 1;
        run(0, 1, 0, 0, 32'h8000_0100, 32'hCAFE_F00D, 8'h0F, 32'h0, 5'd0, 32'h8000_0018);

        // Non-memory op with the downstream stalling.
        defaults;
        hold = 3;
        run(0, 0, 0, 1, 32'h0000_1234, 32'h0, 8'h0, 32'h0, 5'd7, 32'h8000_001C);

        // Error response, then a clean request clears the flag.
        defaults;
        resp_val = 2'b10;
        run(1, 0, 0, 1, 32'h8000_0040, 32'h0, 8'h0, 32'hFFFF_FFFF, 5'd9, 32'h8000_0020);
        defaults;
        run(0, 0, 0, 1, 32'h0000_0055, 32'h0, 8'h0, 32'h0, 5'd10, 32'h8000_0024);

        // Reset while waiting for read data.
        alu_result_input = 32'h8000_0080;
        ren_input = 1'b1;
        wen_input = 1'b0;
        rmask_input = 32'hFFFF_FFFF;
        lsu_receive_valid = 1'b1;
        tick;
        lsu_receive_valid = 1'b0;
        arready = 1'b1;
        tick;
        arready = 1'b0;
        chk("in_r_rready", 32'(rready), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_in_r_rready", 32'(rready), 32'd0);
        chk("rst_in_r_send_valid", 32'(lsu_send_valid), 32'd0);
        chk("rst_in_r_send_ready", 32'(lsu_send_ready), 32'd1);
        tick;
        chk("rst_in_r_no_completion", 32'(lsu_send_valid), 32'd0);

        // Randomized mix including ren+wen together.
        for (int k = 0; k < 40; k++) begin
            defaults;
            ar_dly = $urandom_range(0, 3);
            r_dly  = $urandom_range(0, 3);
            aw_dly = $urandom_range(0, 3);
            w_dly  = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3);
            hold   = $urandom_range(0, 2);
            resp_val = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rn = 1'($urandom);
            wn = 1'($urandom);
            run(rn, wn, 1'($urandom), 1'($urandom), $urandom, $urandom,
                8'($urandom), rmasks[$urandom_range(0, 2)], 5'($urandom), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_axi.md
LSU_AXI -- requirements
Module: lsu_axi

Interface
REQ-001 SHALL have clock `clk`: input, 1 bit; all state updates on its rising edge.
REQ-002 SHALL have reset `rst`: input, 1 bit; synchronous, active-high.
REQ-003 SHALL have `lsu_receive_valid`: input, 1 bit; upstream (EXU) request valid.
REQ-004 SHALL have `lsu_send_ready`: output, 1 bit; LSU can accept an upstream request.
REQ-005 SHALL have `alu_result_input`: input, 32 bits; byte address, or result to pass through.
REQ-006 SHALL have `rsb_input`: input, 32 bits; store data.
REQ-007 SHALL have `ren_input`, `wen_input`, `memory_read_signed_input`, `reg_write_en_input`: inputs, 1 bit each; load enable, store enable, sign-extend load, register write enable.
REQ-008 SHALL have `wmask_input` (input, 8 bits; bits[3:0] are byte strobes, bits[7:4] ignored) and `rmask_input` (input, 32 bits; 0xFF, 0xFFFF or 0xFFFFFFFF).
REQ-009 SHALL have `rd_input` (input, 5 bits) and `pc_next_input` (input, 32 bits); both pass through to the outputs.
REQ-010 SHALL have `lsu_send_valid`: output, 1 bit; result valid to downstream (WBU).
REQ-011 SHALL have `lsu_receive_ready`: input, 1 bit; downstream ready.
REQ-012 SHALL have `result`: output, 32 bits; load data, or the latched alu_result for non-memory operations and stores.
REQ-013 SHALL have `rd`, `reg_write_en`, `pc_next` (outputs, 5/1/32 bits) holding latched copies, and `mem_err` (output, 1 bit) set on a non-zero memory response.
REQ-014 SHALL have AXI4-Lite read master ports: `araddr` (out, 32), `arvalid` (out, 1), `arready` (in, 1), `rdata` (in, 32), `rresp` (in, 2), `rvalid` (in, 1), `rready` (out, 1).
REQ-015 SHALL have AXI4-Lite write master ports: `awaddr` (out, 32), `awvalid` (out, 1), `awready` (in, 1), `wdata` (out, 32), `wstrb` (out, 4), `wvalid` (out, 1), `wready` (in, 1), `bresp` (in, 2), `bvalid` (in, 1), `bready` (out, 1).

Function
REQ-016 SHALL implement the states IDLE, AR, R, AW_W, B, DONE.
REQ-017 SHALL assert lsu_send_ready exactly when in IDLE, and SHALL accept a request and latch all inputs only when lsu_receive_valid && lsu_send_ready.
REQ-018 On accept, SHALL go to AR if ren; otherwise to AW_W if wen; otherwise to DONE with result = alu_result_input. If both ren and wen are set, ren SHALL win and no write is issued.
REQ-019 araddr and awaddr SHALL be {addr[31:2], 2'b00}.
REQ-020 In AR, SHALL assert arvalid, and SHALL go to R on arready.
REQ-021 In R, SHALL assert rready. On rvalid, result SHALL be computed as follows, and the state SHALL go to DONE:
  - d = (rdata >> 8*addr[1:0]) & rmask;
  - if signed and rmask == 0xFF, sign-extend from bit 7;
  - if signed and rmask == 0xFFFF, sign-extend from bit 15.
REQ-022 In AW_W, SHALL assert awvalid and wvalid, with:
  - wdata = rsb << 8*addr[1:0];
  - wstrb = wmask[3:0] << addr[1:0], truncated to 4 bits.
  Each valid SHALL drop independently the cycle after its ready is sampled high. SHALL go to B once both handshakes have completed, including the case where both complete in the same cycle.
REQ-023 In B, SHALL assert bready, and SHALL go to DONE on bvalid with result = latched alu_result.
REQ-024 mem_err SHALL be set to (rresp != 0) or (bresp != 0) on the completing beat, and cleared on the next accept.
REQ-025 In DONE, SHALL hold lsu_send_valid high with all outputs stable until lsu_receive_ready is high, then return to IDLE. A new request SHALL NOT be accepted in that same cycle.
REQ-026 Minimum latency, accept to lsu_send_valid:
  - non-memory operation: 1 cycle;
  - load with arready/rvalid immediately high: 3 cycles;
  - store with awready/wready/bvalid immediately high: 3 cycles.
REQ-027 Every memory-side valid/ready output SHALL be registered and SHALL remain asserted until its handshake completes.

Reset
REQ-028 On rst, SHALL set state to IDLE and drive to 0: lsu_send_valid, result, rd, reg_write_en, pc_next, mem_err, and all AXI valid/ready outputs and address/data/strobe outputs.
REQ-029 Reset mid-transaction SHALL abandon the transaction with no completion; lsu_send_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-030 Load byte signed: addr 0x80000003, rmask 0xFF, signed = 1, rdata 0x80FFFFFF -> araddr 0x80000000; result 0xFFFFFF80; lsu_send_valid 3 cycles after accept.
REQ-031 Store halfword: addr 0x80000002, wmask 0x03, rsb 0x00001234 -> awaddr 0x80000000, wstrb 0xC, wdata 0x12340000; result 0x80000002.
REQ-032 Backpressure: with wready delayed 4 cycles after awready -> awvalid drops after 1 cycle, wvalid is held 5 cycles, and bready is asserted only after both handshakes complete.
REQ-033 Non-memory operation with alu_result 0x1234, lsu_receive_ready held low 3 cycles -> result 0x1234 stable, lsu_send_valid high for 4 cycles, lsu_send_ready 0 throughout.
REQ-034 rresp = 2'b10 on a load -> mem_err = 1 while in DONE; next request accepted -> mem_err = 0.
REQ-035 rst asserted while in R -> next cycle: state IDLE, rready 0, lsu_send_valid 0, lsu_send_ready 1.
